// File: rtl/m_ext_pkg.sv
// m_ext_pkg: shared types and constants for the RV32M divide front/back end.
//   div_op_e           request operation encoding (DIV, DIVU, REM, REMU)
//   div_issue_state_e  issue-unit FSM states
//   DIV_BY_ZERO_Q      quotient returned for a zero divisor (all ones)
//   INT_MIN            most negative 32-bit signed value
package m_ext_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } div_issue_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_special_case.sv
// div_special_case: combinational detection of the RISC-V divide corner cases
// that are answered without running the iterative divider.
//   op_i              requested operation
//   rs1_i / rs2_i     dividend / divisor
//   is_special_o      request is resolved locally
//   special_result_o  architectural result for the special case
module div_special_case
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  div_op_e           op_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic              is_special_o,
    output logic [XLEN-1:0]   special_result_o
);

    always_comb begin
        is_special_o     = 1'b0;
        special_result_o = '0;
        if (rs2_i == '0) begin
            is_special_o     = 1'b1;
            special_result_o = op_is_rem(op_i) ? rs1_i : DIV_BY_ZERO_Q;
        end else if (op_is_signed(op_i) && (rs1_i == INT_MIN) && (rs2_i == '1)) begin
            // Signed overflow: quotient wraps to INT_MIN, remainder is zero.
            is_special_o     = 1'b1;
            special_result_o = op_is_rem(op_i) ? '0 : INT_MIN;
        end
    end

endmodule

// File: rtl/div_issue_unit.sv
// div_issue_unit: RV32M divide issue/retire wrapper around an external
// iterative unsigned divider.
//   clock, nreset                  clock and async active-low reset
//   in_valid/in_ready/in_op/in_rs1/in_rs2/in_tag   request from execute
//   flush                          squash the request in flight
//   out_valid/out_ready/out_data/out_tag           tagged result to writeback
//   div_valid/div_ready/div_a/div_b                operand magnitudes to divider
//   div_q/div_r/div_done           unsigned result and completion pulse
module div_issue_unit
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              div_valid,
    input  logic              div_ready,
    output logic [XLEN-1:0]   div_a,
    output logic [XLEN-1:0]   div_b,
    input  logic [XLEN-1:0]   div_q,
    input  logic [XLEN-1:0]   div_r,
    input  logic              div_done
);

    div_issue_state_e  state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d, rem_q, rem_d;

    div_op_e           op_in;
    logic              is_special;
    logic [XLEN-1:0]   special_result;
    logic              in_signed, in_sign_a, in_sign_b;
    logic [XLEN-1:0]   q_fix, r_fix;

    assign op_in     = div_op_e'(in_op);
    assign in_signed = op_is_signed(op_in);
    assign in_sign_a = in_signed & in_rs1[XLEN-1];
    assign in_sign_b = in_signed & in_rs2[XLEN-1];

    assign q_fix = (sign_a_q ^ sign_b_q) ? (~div_q + 1'b1) : div_q;
    assign r_fix = sign_a_q ? (~div_r + 1'b1) : div_r;

    div_special_case #(.XLEN(XLEN)) u_special (
        .op_i             (op_in),
        .rs1_i            (in_rs1),
        .rs2_i            (in_rs2),
        .is_special_o     (is_special),
        .special_result_o (special_result)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        tag_d     = tag_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        rem_d     = rem_q;
        in_ready  = (state_q == IDLE);
        div_valid = (state_q == ISSUE);
        out_valid = (state_q == RESP);

        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    rem_d    = op_is_rem(op_in);
                    tag_d    = in_tag;
                    a_d      = in_sign_a ? (~in_rs1 + 1'b1) : in_rs1;
                    b_d      = in_sign_b ? (~in_rs2 + 1'b1) : in_rs2;
                    if (is_special) begin
                        data_d  = special_result;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A flush coinciding with div_ready still counts as a handoff,
                // so the divider's eventual done pulse must be drained.
                if (div_ready) begin
                    state_d = flush ? DRAIN : WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Flush in the same cycle as div_done: result is already gone,
                // so return straight to IDLE instead of draining.
                if (div_done) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        data_d  = rem_q ? r_fix : q_fix;
                        state_d = RESP;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (div_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            a_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rem_q    <= rem_d;
        end
    end

    assign out_data = data_q;
    assign out_tag  = tag_q;
    assign div_a    = a_q;
    assign div_b    = b_q;

endmodule

// File: tb/tb_div_issue_unit.sv
// tb_div_issue_unit: directed vector table, hand-written flush/backpressure/
// reset sequences, and a randomized run against a reference divide function.
module tb_div_issue_unit;

    logic        clock = 1'b0;
    logic        nreset;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1, in_rs2, out_data;
    logic [4:0]  in_tag, out_tag;
    logic        div_valid, div_ready, div_done;
    logic [31:0] div_a, div_b, div_q, div_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    div_issue_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_done  (div_done)
    );

    // Behavioural divider: accepts when idle, pulses done lat+1 cycles later.
    logic        mdl_busy, mdl_done, ready_en, spur_done;
    logic [31:0] mdl_qa, mdl_ra;
    int unsigned mdl_cnt, lat;

    assign div_ready = ready_en & ~mdl_busy;
    assign div_done  = mdl_done | spur_done;

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            mdl_busy <= 1'b0;
            mdl_done <= 1'b0;
            mdl_cnt  <= 0;
            div_q    <= '0;
            div_r    <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (mdl_busy) begin
                if (mdl_cnt == 0) begin
                    mdl_done <= 1'b1;
                    div_q    <= mdl_qa;
                    div_r    <= mdl_ra;
                    mdl_busy <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end else if (div_valid && div_ready) begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= lat;
                mdl_qa   <= (div_b != 0) ? div_a / div_b : 32'hFFFF_FFFF;
                mdl_ra   <= (div_b != 0) ? div_a % div_b : div_a;
            end
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn, rem;
        sgn = (op == 2'd0) || (op == 2'd2);
        rem = op[1];
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
        if (sgn) return rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return rem ? a % b : a / b;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'(0 - $urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drives one request from a negedge; returns at the first negedge with
    // out_valid (out_ready low) or one negedge after retirement.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input bit special,
                          input logic [31:0] ea, input logic [31:0] eb);
        int  cyc;
        bit  saw_dv;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        @(negedge clock);
        in_valid = 1'b0;
        saw_dv   = 1'b0;
        cyc      = 1;
        while (!out_valid && cyc < 60) begin
            if (div_valid && !saw_dv) begin
                saw_dv = 1'b1;
                chk("div_a", div_a, ea);
                chk("div_b", div_b, eb);
                chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
            end
            @(negedge clock);
            cyc++;
        end
        chk("resp_seen", {31'b0, out_valid}, 32'd1);
        if (special) begin
            chk("special_latency", cyc, 32'd1);
            chk("special_no_div_req", {31'b0, saw_dv}, 32'd0);
        end else begin
            chk("div_req_seen", {31'b0, saw_dv}, 32'd1);
        end
        chk("out_data", out_data, exp);
        chk("out_tag", {27'b0, out_tag}, {27'b0, tag});
        if (out_ready) begin
            @(negedge clock);
            chk("retire_out_valid", {31'b0, out_valid}, 32'd0);
            chk("retire_in_ready", {31'b0, in_ready}, 32'd1);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        bit          special;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD, 1'b0, 32'd7,         32'd2};
        vecs[1]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, 1'b0, 32'd7,         32'd2};
        vecs[2]  = '{2'd1, 32'd100,       32'd0,         5'd3,  32'hFFFF_FFFF, 1'b1, 32'd0,         32'd0};
        vecs[3]  = '{2'd3, 32'd100,       32'd0,         5'd4,  32'd100,       1'b1, 32'd0,         32'd0};
        vecs[4]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 1'b1, 32'd0,         32'd0};
        vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'd0,         1'b1, 32'd0,         32'd0};
        vecs[6]  = '{2'd0, 32'd7,         32'hFFFF_FFFE, 5'd7,  32'hFFFF_FFFD, 1'b0, 32'd7,         32'd2};
        vecs[7]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 5'd8,  32'd1,         1'b0, 32'd7,         32'd2};
        vecs[8]  = '{2'd1, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'h7FFF_FFFC, 1'b0, 32'hFFFF_FFF9, 32'd2};
        vecs[9]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'd1,         1'b0, 32'hFFFF_FFF9, 32'd2};
        vecs[10] = '{2'd0, 32'hFFFF_FFF9, 32'd0,         5'd11, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'd0};
        vecs[11] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         5'd12, 32'hFFFF_FFF9, 1'b1, 32'd0,         32'd0};
        vecs[12] = '{2'd0, 32'h8000_0000, 32'd2,         5'd13, 32'hC000_0000, 1'b0, 32'h8000_0000, 32'd2};
        vecs[13] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1'b0, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[14] = '{2'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFFE, 1'b0, 32'd8,         32'd3};
        vecs[15] = '{2'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd31, 32'd2,         1'b0, 32'd8,         32'd3};

        nreset    = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        ready_en  = 1'b1;
        spur_done = 1'b0;
        lat       = 2;
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);

        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_div_valid", {31'b0, div_valid}, 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_tag",   {27'b0, out_tag}, 32'd0);
        chk("rst_div_a",     div_a, 32'd0);
        chk("rst_div_b",     div_b, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
                   vecs[i].special, vecs[i].ea, vecs[i].eb);
        end

        // Backpressure: RESP holds for 5 cycles with out_ready low.
        out_ready = 1'b0;
        run_op(2'd0, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_out_data",  out_data, 32'd14);
            chk("hold_out_tag",   {27'b0, out_tag}, 32'd9);
            chk("hold_in_ready",  {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("hold_release", {31'b0, out_valid}, 32'd0);

        // Flush in WAIT; divider finishes ~10 cycles later and is drained.
        lat = 9;
        in_valid = 1'b1; in_op = 2'd0; in_rs1 = 32'd50; in_rs2 = 32'd5; in_tag = 5'd3;
        @(negedge clock);
        in_valid = 1'b0;
        chk("wf_div_valid", {31'b0, div_valid}, 32'd1);
        @(negedge clock);
        chk("wf_in_wait", {31'b0, div_valid | in_ready}, 32'd0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        for (int k = 0; k < 40 && !div_done; k++) begin
            chk("wf_drain_in_ready", {31'b0, in_ready}, 32'd0);
            chk("wf_drain_out_valid", {31'b0, out_valid}, 32'd0);
            @(negedge clock);
        end
        chk("wf_done_seen", {31'b0, div_done}, 32'd1);
        chk("wf_ready_on_done", {31'b0, in_ready}, 32'd0);
        @(negedge clock);
        chk("wf_ready_after", {31'b0, in_ready}, 32'd1);
        chk("wf_no_out_valid", {31'b0, out_valid}, 32'd0);

        // Flush in ISSUE while divider stalls: straight back to IDLE.
        lat = 2;
        ready_en = 1'b0;
        in_valid = 1'b1; in_op = 2'd1; in_rs1 = 32'd9; in_rs2 = 32'd4; in_tag = 5'd4;
        @(negedge clock);
        in_valid = 1'b0;
        chk("if_div_valid", {31'b0, div_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        ready_en = 1'b1;
        chk("if_div_valid_drop", {31'b0, div_valid}, 32'd0);
        chk("if_in_ready", {31'b0, in_ready}, 32'd1);
        chk("if_out_valid", {31'b0, out_valid}, 32'd0);

        // Flush in ISSUE coinciding with div_ready: must drain.
        in_valid = 1'b1; in_op = 2'd1; in_rs1 = 32'd9; in_rs2 = 32'd4; in_tag = 5'd5;
        @(negedge clock);
        in_valid = 1'b0;
        chk("ifr_div_handshake", {31'b0, div_valid & div_ready}, 32'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("ifr_draining", {31'b0, in_ready | div_valid}, 32'd0);
        for (int k = 0; k < 20 && !div_done; k++) @(negedge clock);
        chk("ifr_done_seen", {31'b0, div_done}, 32'd1);
        @(negedge clock);
        chk("ifr_in_ready", {31'b0, in_ready}, 32'd1);
        chk("ifr_no_out_valid", {31'b0, out_valid}, 32'd0);

        // Flush in RESP drops out_valid.
        out_ready = 1'b0;
        run_op(2'd1, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        out_ready = 1'b1;
        chk("rf_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rf_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush with in_valid in IDLE: not accepted.
        in_valid = 1'b1; flush = 1'b1; in_op = 2'd1; in_rs1 = 32'd5; in_rs2 = 32'd3;
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        chk("fi_in_ready", {31'b0, in_ready}, 32'd1);
        chk("fi_busy", {31'b0, out_valid | div_valid}, 32'd0);

        // Stray div_done in IDLE is ignored.
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        chk("spur_out_valid", {31'b0, out_valid}, 32'd0);
        chk("spur_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of a divide.
        lat = 20;
        in_valid = 1'b1; in_op = 2'd0; in_rs1 = 32'hFFFF_FFCE; in_rs2 = 32'd5; in_tag = 5'd17;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        nreset = 1'b0;
        #1;
        chk("mr_in_ready",  {31'b0, in_ready},  32'd1);
        chk("mr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mr_div_valid", {31'b0, div_valid}, 32'd0);
        chk("mr_out_tag",   {27'b0, out_tag}, 32'd0);
        chk("mr_div_a",     div_a, 32'd0);
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);
        chk("mr_idle_after", {31'b0, in_ready}, 32'd1);

        // Randomized ops against the reference function.
        for (int i = 0; i < 1000; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b, ea, eb;
            bit          sgn, sp;
            op  = 2'($urandom_range(0, 3));
            a   = pick();
            b   = pick();
            lat = $urandom_range(0, 4);
            sgn = (op == 2'd0) || (op == 2'd2);
            sp  = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            ea  = (sgn && a[31]) ? 32'(0 - a) : a;
            eb  = (sgn && b[31]) ? 32'(0 - b) : b;
            run_op(op, a, b, 5'(i), ref_div(op, a, b), sp, ea, eb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
